dest_reg_tracker: RTL and testbench

Pipelined destination-register tracker and hazard unit for the 5-stage MIPS core. It consumes the ID-stage destination register chosen by the rt/rd destination mux, along with ID source registers and control flags, and carries them through internal EX/MEM/WB slots. From those slots it generates registered forwarding selects for the EX-stage ALU operands and a load-use stall. It sits alongside the ID/EX pipeline register and is the consumer end of the destination-register path.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/dest_reg_slot.sv | 72 +++++++
 rtl/dest_reg_tracker.sv | 118 +++++++++++
 tb/tb_dest_reg_tracker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: forwarding select encodings and register-index helpers.
package pipeline_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10
    } fwd_sel_e;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/dest_reg_slot.sv
// One pipeline slot of the destination-register tracker (EX, MEM or WB).
module dest_reg_slot #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_bubble,
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_uses_rt,
    input  logic [REG_W-1:0] i_dest,
    input  logic             i_we,
    input  logic             i_mr,
    input  logic             i_valid,
    output logic [REG_W-1:0] o_rs,
    output logic [REG_W-1:0] o_rt,
    output logic             o_uses_rt,
    output logic [REG_W-1:0] o_dest,
    output logic             o_we,
    output logic             o_mr,
    output logic             o_valid
);

    logic [REG_W-1:0] r_rs;
    logic [REG_W-1:0] r_rt;
    logic             r_uses_rt;
    logic [REG_W-1:0] r_dest;
    logic             r_we;
    logic             r_mr;
    logic             r_valid;

    // A bubble clears every field so a squashed slot can never match or write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs      <= '0;
            r_rt      <= '0;
            r_uses_rt <= 1'b0;
            r_dest    <= '0;
            r_we      <= 1'b0;
            r_mr      <= 1'b0;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            if (i_bubble) begin
                r_rs      <= '0;
                r_rt      <= '0;
                r_uses_rt <= 1'b0;
                r_dest    <= '0;
                r_we      <= 1'b0;
                r_mr      <= 1'b0;
                r_valid   <= 1'b0;
            end else begin
                r_rs      <= i_rs;
                r_rt      <= i_rt;
                r_uses_rt <= i_uses_rt;
                r_dest    <= i_dest;
                r_we      <= i_we;
                r_mr      <= i_mr;
                r_valid   <= i_valid;
            end
        end
    end

    assign o_rs      = r_rs;
    assign o_rt      = r_rt;
    assign o_uses_rt = r_uses_rt;
    assign o_dest    = r_dest;
    assign o_we      = r_we;
    assign o_mr      = r_mr;
    assign o_valid   = r_valid;

endmodule

// File: rtl/dest_reg_tracker.sv
// Destination-register tracker: carries ID destinations through EX/MEM/WB slots and
// produces registered EX forwarding selects plus the combinational load-use stall.
module dest_reg_tracker #(
    parameter int REG_W  = 5,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [REG_W-1:0]  wb_dest,
    output logic              wb_we,
    output logic [PERF_W-1:0] stall_count
);

    import pipeline_pkg::*;

    logic [REG_W-1:0] w_ex_rs, w_ex_rt, w_ex_dest;
    logic             w_ex_uses_rt, w_ex_we, w_ex_mr, w_ex_valid;
    logic [REG_W-1:0] w_mem_rs, w_mem_rt, w_mem_dest;
    logic             w_mem_uses_rt, w_mem_we, w_mem_mr, w_mem_valid;
    logic [REG_W-1:0] w_wb_rs, w_wb_rt, w_wb_dest;
    logic             w_wb_uses_rt, w_wb_we, w_wb_mr, w_wb_valid;
    logic             w_unused_wb;

    logic             w_bubble;
    logic             w_ex_live;
    logic             w_mem_live;
    fwd_sel_e         w_fwd_a_nxt;
    fwd_sel_e         w_fwd_b_nxt;
    fwd_sel_e         r_fwd_a;
    fwd_sel_e         r_fwd_b;
    logic [PERF_W-1:0] r_stall_count;

    dest_reg_slot #(.REG_W(REG_W)) u_ex (
        .clk(clk), .rst_n(rst_n), .i_load(1'b1), .i_bubble(w_bubble),
        .i_rs(id_rs), .i_rt(id_rt), .i_uses_rt(id_uses_rt), .i_dest(id_dest),
        .i_we(id_reg_write & id_valid), .i_mr(id_mem_read & id_valid), .i_valid(id_valid),
        .o_rs(w_ex_rs), .o_rt(w_ex_rt), .o_uses_rt(w_ex_uses_rt), .o_dest(w_ex_dest),
        .o_we(w_ex_we), .o_mr(w_ex_mr), .o_valid(w_ex_valid)
    );

    dest_reg_slot #(.REG_W(REG_W)) u_mem (
        .clk(clk), .rst_n(rst_n), .i_load(1'b1), .i_bubble(1'b0),
        .i_rs(w_ex_rs), .i_rt(w_ex_rt), .i_uses_rt(w_ex_uses_rt), .i_dest(w_ex_dest),
        .i_we(w_ex_we), .i_mr(w_ex_mr), .i_valid(w_ex_valid),
        .o_rs(w_mem_rs), .o_rt(w_mem_rt), .o_uses_rt(w_mem_uses_rt), .o_dest(w_mem_dest),
        .o_we(w_mem_we), .o_mr(w_mem_mr), .o_valid(w_mem_valid)
    );

    dest_reg_slot #(.REG_W(REG_W)) u_wb (
        .clk(clk), .rst_n(rst_n), .i_load(1'b1), .i_bubble(1'b0),
        .i_rs(w_mem_rs), .i_rt(w_mem_rt), .i_uses_rt(w_mem_uses_rt), .i_dest(w_mem_dest),
        .i_we(w_mem_we), .i_mr(w_mem_mr), .i_valid(w_mem_valid),
        .o_rs(w_wb_rs), .o_rt(w_wb_rt), .o_uses_rt(w_wb_uses_rt), .o_dest(w_wb_dest),
        .o_we(w_wb_we), .o_mr(w_wb_mr), .o_valid(w_wb_valid)
    );

    // Source fields of the WB slot are carried for completeness but nothing reads them.
    assign w_unused_wb = ^{w_wb_rs, w_wb_rt, w_wb_uses_rt, w_wb_mr, w_wb_valid};

    assign w_ex_live  = w_ex_we  & (w_ex_dest  != REG_W'(REG_ZERO));
    assign w_mem_live = w_mem_we & (w_mem_dest != REG_W'(REG_ZERO));

    assign stall = id_valid & w_ex_mr & w_ex_live &
                   ((w_ex_dest == id_rs) | (id_uses_rt & (w_ex_dest == id_rt)));
    assign w_bubble = stall | flush;

    // The slot now in EX moves to MEM at this edge, so it has priority over the MEM slot.
    always_comb begin
        w_fwd_a_nxt = FWD_REGFILE;
        w_fwd_b_nxt = FWD_REGFILE;
        if (!w_bubble) begin
            if (w_ex_live && (w_ex_dest == id_rs)) begin
                w_fwd_a_nxt = FWD_MEM;
            end else if (w_mem_live && (w_mem_dest == id_rs)) begin
                w_fwd_a_nxt = FWD_WB;
            end
            if (id_uses_rt) begin
                if (w_ex_live && (w_ex_dest == id_rt)) begin
                    w_fwd_b_nxt = FWD_MEM;
                end else if (w_mem_live && (w_mem_dest == id_rt)) begin
                    w_fwd_b_nxt = FWD_WB;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_a       <= FWD_REGFILE;
            r_fwd_b       <= FWD_REGFILE;
            r_stall_count <= '0;
        end else begin
            r_fwd_a <= w_fwd_a_nxt;
            r_fwd_b <= w_fwd_b_nxt;
            if (stall && (r_stall_count != {PERF_W{1'b1}})) begin
                r_stall_count <= r_stall_count + PERF_W'(1);
            end
        end
    end

    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign wb_dest     = w_wb_dest;
    assign wb_we       = w_wb_we & (w_wb_dest != REG_W'(REG_ZERO));
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Scoreboard bench for dest_reg_tracker: directed instruction stream, expectations queued
// per cycle, a negedge monitor pops and compares them.
module tb_dest_reg_tracker;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  id_dest;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [4:0]  wb_dest;
    logic        wb_we;
    logic [15:0] stall_count;

    logic        s_stall;
    logic [1:0]  s_fwd_a;
    logic [1:0]  s_fwd_b;
    logic [4:0]  s_wb_dest;
    logic        s_wb_we;
    logic [3:0]  s_stall_count;

    typedef enum {SIG_STALL, SIG_FWDA, SIG_FWDB, SIG_WBD, SIG_WBWE, SIG_CNT, SIG_CNTS} sig_e;
    typedef struct {
        int    cyc;
        sig_e  sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   expCnt = 0;
    localparam int SAT_MAX = 15;

    dest_reg_tracker #(.REG_W(5), .PERF_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .stall(stall), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .wb_dest(wb_dest), .wb_we(wb_we), .stall_count(stall_count)
    );

    // Narrow-counter copy on the same inputs so saturation is reachable in a short run.
    dest_reg_tracker #(.REG_W(5), .PERF_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .stall(s_stall), .fwd_a(s_fwd_a),
        .fwd_b(s_fwd_b), .wb_dest(s_wb_dest), .wb_we(s_wb_we), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urt, input logic [4:0] dest, input logic rw,
                                 input logic mr, input logic fl);
        step();
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        id_dest      = dest;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
    endtask

    task automatic nop();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic randomInputs();
        id_valid     = 1'($urandom);
        id_rs        = 5'($urandom);
        id_rt        = 5'($urandom);
        id_uses_rt   = 1'($urandom);
        id_dest      = 5'($urandom);
        id_reg_write = 1'($urandom);
        id_mem_read  = 1'($urandom);
        flush        = 1'($urandom);
    endtask

    task automatic expectAt(input int off, input sig_e s, input int v, input string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic expectIdle(input string nm);
        expectAt(0, SIG_STALL, 0, {nm, "_stall"});
        expectAt(0, SIG_FWDA,  0, {nm, "_fwd_a"});
        expectAt(0, SIG_FWDB,  0, {nm, "_fwd_b"});
        expectAt(0, SIG_WBD,   0, {nm, "_wb_dest"});
        expectAt(0, SIG_WBWE,  0, {nm, "_wb_we"});
        expectAt(0, SIG_CNT,   0, {nm, "_count"});
        expectAt(0, SIG_CNTS,  0, {nm, "_count_narrow"});
    endtask

    task automatic checkOutput(input exp_t e);
        int act;
        case (e.sig)
            SIG_STALL: act = int'(stall);
            SIG_FWDA:  act = int'(fwd_a);
            SIG_FWDB:  act = int'(fwd_b);
            SIG_WBD:   act = int'(wb_dest);
            SIG_WBWE:  act = int'(wb_we);
            SIG_CNT:   act = int'(stall_count);
            default:   act = int'(s_stall_count);
        endcase
        total++;
        if (act != e.val) begin
            bad++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", e.name, e.cyc, act, e.val);
        end
    endtask

    // Monitor: every negedge, compare all expectations scheduled for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    checkOutput(sb[i]);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        randomInputs();

        for (int r = 0; r < 3; r++) begin
            step();
            randomInputs();
            expectIdle("reset");
        end

        // c0: add $3 <- $1,$2 ; released from reset in the same cycle
        applyStimulus(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        rst_n = 1'b1;
        expectAt(1, SIG_FWDA, 0, "first_fwd_a");
        expectAt(1, SIG_FWDB, 0, "first_fwd_b");
        expectAt(3, SIG_WBD, 3, "add_wb_dest");
        expectAt(3, SIG_WBWE, 1, "add_wb_we");
        // c1: sub rs=$3
        applyStimulus(1, 5'd3, 5'd4, 1, 5'd6, 1, 0, 0);
        expectAt(0, SIG_STALL, 0, "alu_no_stall");
        expectAt(1, SIG_FWDA, 2, "dist1_fwd_a");
        expectAt(1, SIG_FWDB, 0, "dist1_fwd_b");
        expectAt(3, SIG_WBD, 6, "sub_wb_dest");
        // c2: rs=$3 two after the writer
        applyStimulus(1, 5'd3, 5'd12, 1, 5'd13, 1, 0, 0);
        expectAt(1, SIG_FWDA, 1, "dist2_fwd_a");
        expectAt(1, SIG_FWDB, 0, "dist2_fwd_b");
        // c3: rs=$3 three after; rt=$13 matches EX but rt is not used
        applyStimulus(1, 5'd3, 5'd13, 0, 5'd14, 1, 0, 0);
        expectAt(1, SIG_FWDA, 0, "dist3_fwd_a");
        expectAt(1, SIG_FWDB, 0, "rt_unused_fwd_b");

        // c4: lw $5 ; c5/c6: add reading rt=$5 (held in ID during the stall)
        applyStimulus(1, 5'd1, 5'd5, 0, 5'd5, 1, 1, 0);
        expectAt(3, SIG_WBD, 5, "lw_wb_dest");
        expectAt(3, SIG_WBWE, 1, "lw_wb_we");
        applyStimulus(1, 5'd6, 5'd5, 1, 5'd7, 1, 0, 0);
        expectAt(0, SIG_STALL, 1, "loaduse_stall");
        expectAt(0, SIG_CNT, 0, "loaduse_count_before");
        expCnt = 1;
        applyStimulus(1, 5'd6, 5'd5, 1, 5'd7, 1, 0, 0);
        expectAt(0, SIG_STALL, 0, "loaduse_stall_drop");
        expectAt(0, SIG_FWDA, 0, "bubble_fwd_a");
        expectAt(0, SIG_FWDB, 0, "bubble_fwd_b");
        expectAt(0, SIG_CNT, 1, "loaduse_count");
        expectAt(1, SIG_FWDA, 0, "loaduse_fwd_a");
        expectAt(1, SIG_FWDB, 1, "loaduse_fwd_b");

        // Double hazard on $7: MEM wins over WB
        applyStimulus(1, 5'd0, 5'd0, 0, 5'd7, 1, 0, 0);
        applyStimulus(1, 5'd0, 5'd0, 0, 5'd7, 1, 0, 0);
        applyStimulus(1, 5'd7, 5'd7, 1, 5'd20, 1, 0, 0);
        expectAt(0, SIG_STALL, 0, "double_no_stall");
        expectAt(1, SIG_FWDA, 2, "double_fwd_a");
        expectAt(1, SIG_FWDB, 2, "double_fwd_b");

        // Register zero never forwards or writes
        applyStimulus(1, 5'd1, 5'd0, 0, 5'd0, 1, 0, 0);
        expectAt(3, SIG_WBD, 0, "zero_wb_dest");
        expectAt(3, SIG_WBWE, 0, "zero_wb_we");
        applyStimulus(1, 5'd0, 5'd0, 1, 5'd21, 1, 0, 0);
        expectAt(1, SIG_FWDA, 0, "zero_fwd_a");
        expectAt(1, SIG_FWDB, 0, "zero_fwd_b");
        // Invalid ID slot: dest travels, write enable does not
        applyStimulus(0, 5'd1, 5'd0, 0, 5'd9, 1, 0, 0);
        expectAt(3, SIG_WBD, 9, "invalid_wb_dest");
        expectAt(3, SIG_WBWE, 0, "invalid_wb_we");
        applyStimulus(1, 5'd1, 5'd0, 0, 5'd0, 1, 1, 0);
        applyStimulus(1, 5'd0, 5'd0, 1, 5'd24, 1, 0, 0);
        expectAt(0, SIG_STALL, 0, "zero_load_no_stall");

        // Flush coinciding with a load-use stall
        applyStimulus(1, 5'd1, 5'd8, 0, 5'd8, 1, 1, 0);
        applyStimulus(1, 5'd8, 5'd2, 1, 5'd23, 1, 0, 1);
        expectAt(0, SIG_STALL, 1, "flush_stall");
        expCnt = 2;
        expectAt(1, SIG_FWDA, 0, "flush_stall_fwd_a");
        expectAt(1, SIG_FWDB, 0, "flush_stall_fwd_b");
        expectAt(1, SIG_CNT, 2, "flush_stall_count");
        nop();
        expectAt(0, SIG_STALL, 0, "after_flush_stall");
        // Flushed writer must not forward to the next instruction
        applyStimulus(1, 5'd1, 5'd0, 0, 5'd22, 1, 0, 1);
        applyStimulus(1, 5'd22, 5'd0, 0, 5'd25, 1, 0, 0);
        expectAt(1, SIG_FWDA, 0, "flushed_writer_fwd_a");
        nop();
        nop();

        // Repeated lw $5 reading $5: stalls on every other cycle
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0);
            expectAt(0, SIG_STALL, k % 2, "run_stall");
            if (k % 2 == 1) begin
                expCnt++;
                expectAt(1, SIG_CNT, expCnt, "run_count");
                expectAt(1, SIG_CNTS, (expCnt > SAT_MAX) ? SAT_MAX : expCnt, "run_count_narrow");
            end
        end

        // Reset with a full pipeline discards everything
        applyStimulus(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        applyStimulus(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        step();
        rst_n = 1'b0;
        expectIdle("midreset");
        applyStimulus(1, 5'd3, 5'd0, 0, 5'd4, 1, 0, 0);
        rst_n = 1'b1;
        expCnt = 0;
        expectAt(1, SIG_FWDA, 0, "post_reset_fwd_a");
        expectAt(1, SIG_CNT, 0, "post_reset_count");
        expectAt(3, SIG_WBD, 4, "post_reset_wb_dest");
        expectAt(3, SIG_WBWE, 1, "post_reset_wb_we");

        for (int d = 0; d < 5; d++) nop();

        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s never checked (cycle %0d): got none, expected %0d",
                     sb[0].name, sb[0].cyc, sb[0].val);
            sb.delete(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
